// File: rtl/sort_pkg.sv
// Shared types and defaults for the bubble sorter and its output-side serializer.
package sort_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned DATA_N_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Element/vector convention: element 0 sits in the least significant slot.
    typedef logic [DATA_W_DEF-1:0] elem_t;
    typedef elem_t [DATA_N_DEF-1:0] vec_t;

endpackage

// File: rtl/sort_order_chk.sv
// Combinational adjacent-pair comparator: flags a vector that is not ascending (unsigned).
module sort_order_chk
    import sort_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DATA_N = DATA_N_DEF
) (
    input  logic [DATA_N-1:0][DATA_W-1:0] vec,
    output logic                          unsorted
);

    // Equal neighbours are legal; only a strict descent counts.
    always_comb begin
        unsorted = 1'b0;
        for (int i = 0; i < int'(DATA_N) - 1; i++) begin
            if (vec[i] > vec[i+1]) begin
                unsorted = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sort_vec_serializer.sv
// Captures one sorted vector and streams its elements one per beat, index 0 first.
// Optional sticky order_err output when SORT_ORDER_CHECK_EN is defined.
module sort_vec_serializer
    import sort_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DATA_N = DATA_N_DEF,
    parameter int unsigned IDX_W  = $clog2(DATA_N)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vec_valid,
    output logic                          vec_ready,
    input  logic [DATA_N-1:0][DATA_W-1:0] vec_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [IDX_W-1:0]              out_idx,
    output logic                          out_last,
    output logic                          busy
`ifdef SORT_ORDER_CHECK_EN
    ,
    output logic                          order_err
`endif
);

    ser_state_t                    state_q;
    ser_state_t                    state_d;
    logic [DATA_N-1:0][DATA_W-1:0] hold_q;
    logic [IDX_W-1:0]              idx_q;
    logic                          accept_c;
    logic                          elem_hs_c;
    logic                          last_hs_c;

    // Outputs decode directly from registers; only vec_ready is combinational.
    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_idx   = idx_q;
    assign out_data  = hold_q[idx_q];
    assign out_last  = (idx_q == IDX_W'(DATA_N - 1));

    assign elem_hs_c = out_valid & out_ready;
    assign last_hs_c = elem_hs_c & out_last;
    assign vec_ready = (state_q == IDLE) | last_hs_c;
    assign accept_c  = vec_valid & vec_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A last-beat handshake with a simultaneous accept stays in SEND without a bubble.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_hs_c && !accept_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            idx_q  <= '0;
        end else if (accept_c) begin
            hold_q <= vec_data;
            idx_q  <= '0;
        end else if (elem_hs_c) begin
            idx_q  <= out_last ? '0 : idx_q + IDX_W'(1);
        end
    end

`ifdef SORT_ORDER_CHECK_EN
    logic unsorted_c;

    sort_order_chk #(
        .DATA_W (DATA_W),
        .DATA_N (DATA_N)
    ) u_order_chk (
        .vec      (vec_data),
        .unsorted (unsorted_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_err <= 1'b0;
        end else if (accept_c && unsorted_c) begin
            order_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/sort_vec_serializer.md
Name: sort_vec_serializer

Overview:
- Output-side consumer for the pipelined bubble sorter: accepts one sorted vector of DATA_N elements, each DATA_W bits, through a valid/ready handshake.
- Streams the elements one per beat on a valid/ready element port, lowest index first.
- Sits between the sorter's data_o and narrow downstream logic, such as a checker, FIFO or output bus.

Parameters:
- DATA_W, 4, element width in bits.
- DATA_N, 4, elements per vector; must be >= 2.
- IDX_W, $clog2(DATA_N), element index width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vec_valid  in  1  input vector valid.
- vec_ready  out  1  block can capture a vector this cycle.
- vec_data  in  [DATA_N-1:0][DATA_W-1:0]  packed sorted vector; element 0 = smallest.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the element.
- out_data  out  DATA_W  current element.
- out_idx  out  IDX_W  index of the current element within its vector.
- out_last  out  1  current element is index DATA_N-1.
- busy  out  1  a vector is held and not yet fully sent.

Behaviour:
- Reset is asynchronous, active-low. While rst_n = 0 and after release:
  - state = IDLE; out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, busy = 0.
  - Hold register is cleared to 0; vec_ready = 1.
- States:
  - IDLE: no vector held.
  - SEND: vector held, elements being emitted.
- vec_ready (combinational) = (state == IDLE) | (out_valid & out_ready & out_last).
- vec_ready never depends on vec_valid.
- Vector accept = vec_valid & vec_ready. On accept:
  - Capture vec_data into the hold register and set out_idx = 0.
  - Go to, or stay in, SEND.
  - out_valid is 1 in the cycle after the accepting edge: 1-cycle latency.
- Element emission:
  - out_data = hold[out_idx]; out_last = (out_idx == DATA_N-1).
  - Element handshake = out_valid & out_ready. On a handshake with out_last = 0, out_idx increments.
- Last-beat handshake:
  - If a vector is accepted in the same cycle: load the new vector, out_idx = 0, stay in SEND. No bubble; DATA_N elements per DATA_N cycles is sustained.
  - Otherwise: go to IDLE, out_valid = 0, out_idx = 0.
- Backpressure: while out_valid = 1 and out_ready = 0, out_data, out_idx and out_last hold stable. out_valid never drops without a handshake.
- vec_valid in SEND before the last-beat handshake is ignored; vec_ready = 0 and the sender must hold its data.
- out_idx never exceeds DATA_N-1. The wrap back to 0 happens only through a vector load or a return to IDLE.
- Reset asserted mid-SEND: the held vector is dropped, all outputs return to reset values immediately, and there is no partial completion.
- busy = (state == SEND).
- No arithmetic on data; elements pass through bit-exact.

Optional Feature:
- Macro: SORT_ORDER_CHECK_EN.
- Defined:
  - Extra output order_err, 1 bit, reset 0.
  - On each vector accept, adjacent elements are compared unsigned. If any vec_data[i] > vec_data[i+1], order_err sets on that edge and stays 1 (sticky) until reset.
  - Equal neighbours are legal.
  - Streaming is unaffected.
- Undefined: no order_err port and no comparator logic.

Decomposition:
- Package sort_pkg holds:
  - DATA_W_DEF = 4, DATA_N_DEF = 4;
  - typedef enum logic {IDLE, SEND} ser_state_t;
  - the parameterised element/vector typedef convention shared with the sorter.
- Sub-module sort_order_chk: combinational adjacent-pair comparator chain, output unsorted. Instantiated only under SORT_ORDER_CHECK_EN; reusable by the sorter's bench.

Test Plan:
- Reset mid-vector: assert rst_n = 0 after 2 of 4 beats -> out_valid = 0, out_idx = 0 and vec_ready = 1 at once. After release, a fresh vector streams from index 0.
- Basic stream, DATA_N = 4, DATA_W = 4, out_ready = 1: accept {e0=3, e1=7, e2=9, e3=12} -> next 4 cycles give out_data 3, 7, 9, 12; out_idx 0..3; out_last only with 12; then IDLE with vec_ready = 1.
- Backpressure: same vector, out_ready = 0 for 3 cycles after the first handshake -> out_data = 7 and out_idx = 1 held stable with out_valid = 1; the stream then resumes 9, 12.
- Back-to-back: second vector {1, 1, 2, 15} presented with vec_valid during the beat carrying 12 -> accepted that cycle; 8 elements in 8 consecutive cycles with no out_valid gap.
- Busy reject: vec_valid = 1 with {0, 0, 0, 0} during beat 1 -> vec_ready = 0, nothing captured, and the current stream is unchanged.
- SORT_ORDER_CHECK_EN: accept {5, 2, 8, 9} -> order_err = 1 from the next cycle and sticky, while all four elements still stream. After reset, {4, 4, 4, 4} -> order_err stays 0.
